nios_system_onchip_ram_dp: RTL
==============================

# nios_system_onchip_ram_dp

Parametrised dual-port on-chip RAM exposing two independent Avalon-MM slave ports (s1, s2) on one clock, for Nios II systems that need a data path and a DMA/peripheral path into the same memory. Generalises the single-port on-chip memory with configurable width, depth and read latency, explicit `readdatavalid` pipelining, defined cross-port collision behaviour and a clock-enable freeze.

## Interface
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 15: word address width; depth = 2^ADDR_WIDTH.
- `READ_LATENCY`, 1: cycles from read acceptance to data; legal values 1 or 2, any other value is an elaboration error.
- `INIT_FILE`, "nios_system_onchip_ram_dp.hex": memory initialisation file.

Ports; `x` = s1 or s2, with one identical set per port:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `clken`  in  1  global clock enable; low freezes the block.
- `reset_req`  in  1  high freezes the block, same as `clken` low.
- `x_address`  in  ADDR_WIDTH  word address.
- `x_byteenable`  in  DATA_WIDTH/8  write byte lanes.
- `x_chipselect`  in  1  port select.
- `x_read`  in  1  read request.
- `x_write`  in  1  write request.
- `x_writedata`  in  DATA_WIDTH  write data.
- `x_readdata`  out  DATA_WIDTH  read data.
- `x_readdatavalid`  out  1  `x_readdata` is valid this cycle.

## Operation
- Enable: `en = clken & ~reset_req`. When `en` is 0:
  - no write is performed;
  - no read is accepted;
  - the read pipeline and all outputs hold their values.
- Write: `x_chipselect & x_write & en`. Each byte lane i with `x_byteenable[i]=1` is written; other lanes are unchanged.
- Read: `x_chipselect & x_read & ~x_write & en`.
  - The read is accepted and a valid token enters the port's READ_LATENCY-deep pipeline.
  - Read and write asserted together on the same port: the write wins and no read is issued.
- No waitrequest. Each port accepts one request per cycle, fully pipelined.
- Same-address writes on both ports in the same cycle: s1's data wins on every lane enabled on s1; lanes enabled only on s2 take s2's data.
- Cross-port read-during-write (one port reads the address the other writes in the same cycle): result depends on `ONCHIP_RAM_DP_FWD_EN` (see Configuration).
- Same-port sequencing: a read accepted in the cycle after a write to the same address returns the new data.
- Reset (`reset_n=0` at a clock edge):
  - `x_readdatavalid` = 0 and `x_readdata` = 0 on both ports;
  - pipeline tokens in flight are discarded;
  - memory contents are NOT cleared;
  - reset takes priority over `en`.
- Reads in flight when reset asserts are lost and never signalled valid.

## Timing
- READ_LATENCY=1: read accepted at edge N → `x_readdata`/`x_readdatavalid` valid after edge N+1, for exactly one cycle per accepted read.
- READ_LATENCY=2: RAM output is registered again → valid after edge N+2.
- Back-to-back reads: one valid result per cycle, in issue order.
- Frozen cycles (`en`=0) stretch latency by the number of frozen edges; order is preserved.
- `x_readdata` holds its last value when `x_readdatavalid`=0.
- A write is visible to a read on either port accepted at edge N+1 or later.

## Configuration
- `ONCHIP_RAM_DP_FWD_EN` defined: cross-port read-during-write returns the new data, merged per byte lane (enabled lanes from the writer, others from the array). This is implemented with a comparator and bypass mux per port, aligned to the read pipeline.
- Not defined: a cross-port read-during-write returns the old data, and no bypass logic is built.
- Same-port behaviour and same-address write priority are identical in both builds.

## Test plan
- Reset, then a read of word 0x10 with READ_LATENCY=1 → `s1_readdatavalid`=1 exactly one cycle later, `s1_readdata` = INIT_FILE word 0x10; both valids stay 0 while `reset_n`=0.
- s1 writes 0xDEADBEEF to 0x20 with `byteenable`=4'b0101, prior content 0x11223344 → an s2 read of 0x20 returns 0x11AD33EF.
- Same cycle, s1 writes 0xAAAAAAAA (be 4'b1100) and s2 writes 0x55555555 (be 4'b0011) to 0x30 → a subsequent read returns 0xAAAA5555; repeat with both be=4'b1111 → 0xAAAAAAAA.
- s1 writes 0x12345678 to 0x40 while s2 reads 0x40 in the same cycle, old content 0 → s2 gets 0x12345678 with `ONCHIP_RAM_DP_FWD_EN` defined, 0x00000000 without.
- READ_LATENCY=2: 4 back-to-back s2 reads, `clken` dropped for 2 cycles after the second read → 4 valids in order, last valid at cycle 3+2+2; no valid during the frozen cycles.
- 3 reads in flight, `reset_n` pulsed low for 1 cycle → no `readdatavalid` for those reads, and readdata = 0 afterwards.

Source files
------------

// File: rtl/nios_system_onchip_ram_dp.sv
// Dual-port Avalon-MM on-chip RAM: two independent slave ports, byte lanes, 1- or 2-cycle read latency.
// Define ONCHIP_RAM_DP_FWD_EN to make cross-port read-during-write return the newly written bytes.
module nios_system_onchip_ram_dp #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 15,
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = "nios_system_onchip_ram_dp.hex"
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic                    reset_req,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    if ((READ_LATENCY != 1 && READ_LATENCY != 2) || (DATA_WIDTH % 8 != 0)) begin : g_bad_config
        $error("nios_system_onchip_ram_dp: READ_LATENCY must be 1 or 2 and DATA_WIDTH a multiple of 8");
    end

    (* ram_init_file = INIT_FILE *)
    logic [NUM_BYTES-1:0][7:0] mem [DEPTH];

    logic                  en;
    logic [ADDR_WIDTH-1:0] address       [2];
    logic [NUM_BYTES-1:0]  byteenable    [2];
    logic [DATA_WIDTH-1:0] writedata     [2];
    logic                  wr_en         [2];
    logic                  rd_en         [2];
    logic [DATA_WIDTH-1:0] readdata      [2];
    logic                  readdatavalid [2];

    assign en = clken & ~reset_req;

    assign address[0]    = s1_address;
    assign address[1]    = s2_address;
    assign byteenable[0] = s1_byteenable;
    assign byteenable[1] = s2_byteenable;
    assign writedata[0]  = s1_writedata;
    assign writedata[1]  = s2_writedata;
    assign wr_en[0]      = s1_chipselect & s1_write & en;
    assign wr_en[1]      = s2_chipselect & s2_write & en;
    assign rd_en[0]      = s1_chipselect & s1_read & ~s1_write & en;
    assign rd_en[1]      = s2_chipselect & s2_read & ~s2_write & en;

    assign s1_readdata      = readdata[0];
    assign s1_readdatavalid = readdatavalid[0];
    assign s2_readdata      = readdata[1];
    assign s2_readdatavalid = readdatavalid[1];

    // s2 is written first so that s1 overrides it on lanes both ports enable at one address
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (wr_en[1] && byteenable[1][b]) begin
                mem[address[1]][b] <= writedata[1][8*b +: 8];
            end
            if (wr_en[0] && byteenable[0][b]) begin
                mem[address[0]][b] <= writedata[0][8*b +: 8];
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        localparam int OTHER = 1 - gi;

        logic [DATA_WIDTH-1:0] ram_q_reg;
        logic                  v1_reg;
        logic [DATA_WIDTH-1:0] stage1;
        logic                  valid_int;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                ram_q_reg <= '0;
                v1_reg    <= 1'b0;
            end else if (en) begin
                v1_reg <= rd_en[gi];
                if (rd_en[gi]) begin
                    ram_q_reg <= mem[address[gi]];
                end
            end
        end

`ifdef ONCHIP_RAM_DP_FWD_EN
        // Captured alongside the array read so the merge lines up with ram_q_reg.
        logic [NUM_BYTES-1:0]  fwd_mask_reg;
        logic [DATA_WIDTH-1:0] fwd_data_reg;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                fwd_mask_reg <= '0;
                fwd_data_reg <= '0;
            end else if (rd_en[gi]) begin
                fwd_mask_reg <= (wr_en[OTHER] && (address[OTHER] == address[gi]))
                                ? byteenable[OTHER] : '0;
                fwd_data_reg <= writedata[OTHER];
            end
        end

        for (genvar gb = 0; gb < NUM_BYTES; gb++) begin : g_lane
            assign stage1[8*gb +: 8] = fwd_mask_reg[gb] ? fwd_data_reg[8*gb +: 8]
                                                        : ram_q_reg[8*gb +: 8];
        end
`else
        assign stage1 = ram_q_reg;
`endif

        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] out_reg;
            logic                  v2_reg;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    out_reg <= '0;
                    v2_reg  <= 1'b0;
                end else if (en) begin
                    v2_reg <= v1_reg;
                    if (v1_reg) begin
                        out_reg <= stage1;
                    end
                end
            end

            assign readdata[gi] = out_reg;
            assign valid_int    = v2_reg;
        end else begin : g_lat1
            assign readdata[gi] = stage1;
            assign valid_int    = v1_reg;
        end

        // A result is delivered only in a cycle whose closing edge is enabled, so a
        // token waiting through a freeze is signalled exactly once.
        assign readdatavalid[gi] = valid_int & en & reset_n;
    end

endmodule
